// File: rtl/ddr_write_serializer_pkg.sv
// Shared types and default sizes for the DDR write-path serializer.
// Holds the FSM state encoding and the fixed-width helper typedefs.
package ddr_write_serializer_pkg;

  localparam int unsigned DDR_BURST_LEN = 8;
  localparam int unsigned DDR_DATA_W    = 16;

  typedef logic         ulogic1;
  typedef logic [2:0]   ulogic3;
  typedef logic [15:0]  ulogic16;
  typedef logic [127:0] ulogic128;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    BURST,
    POSTAMBLE
  } ddr_wr_state_t;

endpackage

// File: rtl/ddr_burst_shifter.sv
// Parallel-load burst register that presents one beat per cycle.
// dq, dm, dqs and beat_idx are registered and forced to 0 while neither loading nor advancing.
module ddr_burst_shifter
  import ddr_write_serializer_pkg::*;
#(
  parameter  int unsigned DATA_W    = DDR_DATA_W,
  parameter  int unsigned BURST_LEN = DDR_BURST_LEN,
  localparam int unsigned BEAT_W    = $clog2(BURST_LEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        advance,
  input  logic [BURST_LEN*DATA_W-1:0] load_data,
  input  logic [BURST_LEN-1:0]        load_mask,
  output logic [DATA_W-1:0]           dq,
  output logic                        dm,
  output logic                        dqs,
  output logic [BEAT_W-1:0]           beat_idx,
  output logic                        last_c
);

  logic [BURST_LEN*DATA_W-1:0] data_q;
  logic [BURST_LEN-1:0]        mask_q;
  logic [BEAT_W-1:0]           next_c;

  assign next_c = beat_idx + BEAT_W'(1);
  assign last_c = (beat_idx == BEAT_W'(BURST_LEN - 1));

  // Strobe is high on even beats so every beat boundary is an edge, including across chained bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      mask_q   <= '0;
      beat_idx <= '0;
      dq       <= '0;
      dm       <= 1'b0;
      dqs      <= 1'b0;
    end else if (load) begin
      data_q   <= load_data;
      mask_q   <= load_mask;
      beat_idx <= '0;
      dq       <= load_data[DATA_W-1:0];
      dm       <= load_mask[0];
      dqs      <= 1'b1;
    end else if (advance) begin
      beat_idx <= next_c;
      dq       <= data_q[32'(next_c)*DATA_W +: DATA_W];
      dm       <= mask_q[next_c];
      dqs      <= ~next_c[0];
    end else begin
      beat_idx <= '0;
      dq       <= '0;
      dm       <= 1'b0;
      dqs      <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_write_serializer.sv
// DDR write-path transmitter: accepts whole bursts into a one-entry holding
// register and serializes them with preamble, alternating strobe and postamble.
module ddr_write_serializer
  import ddr_write_serializer_pkg::*;
#(
  parameter  int unsigned DATA_W          = DDR_DATA_W,
  parameter  int unsigned BURST_LEN       = DDR_BURST_LEN,
  parameter  int unsigned PREAMBLE_CYCLES = 1,
  localparam int unsigned BEAT_W          = $clog2(BURST_LEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [BURST_LEN*DATA_W-1:0] wr_data,
  input  logic [BURST_LEN-1:0]        wr_mask,
  output logic [DATA_W-1:0]           dq,
  output logic                        dm,
  output logic                        dqs,
  output logic                        dq_oe,
  output logic [BEAT_W-1:0]           beat_idx,
  output logic                        busy
);

  localparam int unsigned PRE_W = 2;

  ddr_wr_state_t               state, state_d;
  logic [PRE_W-1:0]            pre_cnt, pre_cnt_d;
  logic                        hold_v, hold_v_d;
  logic [BURST_LEN*DATA_W-1:0] hold_data;
  logic [BURST_LEN-1:0]        hold_mask;
  logic                        accept_c, load_c, advance_c, last_c;

  assign accept_c = wr_valid && wr_ready;

  // Next state; a burst waiting at the last beat chains straight into beat 0.
  always_comb begin
    state_d   = state;
    pre_cnt_d = pre_cnt;
    load_c    = 1'b0;
    advance_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_v) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PRE_W'(PREAMBLE_CYCLES - 1);
        end
      end
      PREAMBLE: begin
        if (pre_cnt == '0) begin
          state_d = BURST;
          load_c  = 1'b1;
        end else begin
          pre_cnt_d = pre_cnt - PRE_W'(1);
        end
      end
      BURST: begin
        if (!last_c)     advance_c = 1'b1;
        else if (hold_v) load_c    = 1'b1;
        else             state_d   = POSTAMBLE;
      end
      POSTAMBLE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    hold_v_d = hold_v;
    if (load_c)   hold_v_d = 1'b0;
    if (accept_c) hold_v_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      hold_v    <= 1'b0;
      hold_data <= '0;
      hold_mask <= '0;
    end else begin
      state   <= state_d;
      pre_cnt <= pre_cnt_d;
      hold_v  <= hold_v_d;
      if (accept_c) begin
        hold_data <= wr_data;
        hold_mask <= wr_mask;
      end
    end
  end

  // Status outputs are registered from next-state values so they line up with the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dq_oe    <= 1'b0;
      busy     <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      dq_oe    <= (state_d != IDLE);
      busy     <= (state_d != IDLE) || hold_v_d;
      wr_ready <= !hold_v_d;
    end
  end

  ddr_burst_shifter #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .advance   (advance_c),
    .load_data (hold_data),
    .load_mask (hold_mask),
    .dq        (dq),
    .dm        (dm),
    .dqs       (dqs),
    .beat_idx  (beat_idx),
    .last_c    (last_c)
  );

endmodule

// File: tb/tb_ddr_write_serializer.sv
// Self-checking bench for ddr_write_serializer: scoreboard of expected beats
// plus cycle-accurate preamble/postamble checks on PREAMBLE_CYCLES=1 and =3 instances.
module tb_ddr_write_serializer;

  typedef struct {
    logic [15:0] data;
    logic        dm;
    logic [2:0]  idx;
    logic        chained;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic [7:0]   wr_mask;
  logic [15:0]  dq;
  logic         dm, dqs, dq_oe, busy;
  logic [2:0]   beat_idx;

  logic         wr_valid3, wr_ready3;
  logic [127:0] wr_data3;
  logic [7:0]   wr_mask3;
  logic [15:0]  dq3;
  logic         dm3, dqs3, dq_oe3, busy3;
  logic [2:0]   beat_idx3;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ddr_write_serializer #(.DATA_W(16), .BURST_LEN(8), .PREAMBLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask), .dq(dq), .dm(dm), .dqs(dqs),
    .dq_oe(dq_oe), .beat_idx(beat_idx), .busy(busy)
  );

  ddr_write_serializer #(.DATA_W(16), .BURST_LEN(8), .PREAMBLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .wr_data(wr_data3), .wr_mask(wr_mask3), .dq(dq3), .dm(dm3), .dqs(dqs3),
    .dq_oe(dq_oe3), .beat_idx(beat_idx3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // A beat is on the bus when driven and either strobe high or a nonzero index.
  always @(negedge clk) begin
    if (reset && dq_oe && (dqs || beat_idx != 3'd0)) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {16'd0, dq}, 32'hffff_ffff);
      end else begin
        mon_e = sb.pop_front();
        check("dq", {16'd0, dq}, {16'd0, mon_e.data});
        check("dm", {31'd0, dm}, {31'd0, mon_e.dm});
        check("beat_idx", {29'd0, beat_idx}, {29'd0, mon_e.idx});
        check("dqs", {31'd0, dqs}, {31'd0, ~mon_e.idx[0]});
        check("busy", {31'd0, busy}, 32'd1);
        if (mon_e.chained) check("gapless", 32'(cyc - last_cyc), 32'd1);
        last_cyc = cyc;
      end
    end
  end

  task automatic send_burst(input logic [15:0] base, input logic [7:0] mask, input logic chained);
    logic rdy;
    bit   done;
    exp_t e;
    done = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    for (int k = 0; k < 8; k++) wr_data[k*16 +: 16] = base + 16'(k);
    wr_mask = mask;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      rdy = wr_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    if (!done) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < 8; k++) begin
        e.data    = base + 16'(k);
        e.dm      = mask[k];
        e.idx     = 3'(k);
        e.chained = chained && (k == 0);
        sb.push_back(e);
      end
      #3;
      check("rdy_drop", {31'd0, wr_ready}, 32'd0);
    end
  endtask

  task automatic wait_beat(input logic [2:0] idx);
    bit found;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk); #1;
      if (dq_oe && beat_idx == idx && (dqs || idx != 3'd0)) found = 1;
    end
    if (!found) check("wait_beat_timeout", 32'd0, 32'd1);
  endtask

  // Waits for the scoreboard to empty, then expects exactly one postamble and IDLE.
  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) done = 1;
    end
    if (!done) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end else begin
      check("post_oe", {31'd0, dq_oe}, 32'd1);
      check("post_dqs", {31'd0, dqs}, 32'd0);
      check("post_dq", {16'd0, dq}, 32'd0);
      check("post_dm", {31'd0, dm}, 32'd0);
      @(posedge clk); #2;
      check("idle_oe", {31'd0, dq_oe}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_ready", {31'd0, wr_ready}, 32'd1);
    end
  endtask

  task automatic single_burst(input logic [15:0] base, input logic [7:0] mask);
    send_burst(base, mask, 1'b0);
    wr_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_oe", {31'd0, dq_oe}, 32'd1);
    check("pre_dqs", {31'd0, dqs}, 32'd0);
    check("pre_dq", {16'd0, dq}, 32'd0);
    @(posedge clk); #2;
    check("beat0_dqs", {31'd0, dqs}, 32'd1);
    check("beat0_dq", {16'd0, dq}, {16'd0, base});
    wait_drain();
  endtask

  task automatic p3_burst();
    logic rdy;
    bit   done;
    done = 0;
    @(posedge clk); #1;
    wr_valid3 = 1'b1;
    for (int k = 0; k < 8; k++) wr_data3[k*16 +: 16] = 16'h5000 + 16'(k);
    wr_mask3 = 8'h00;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      rdy = wr_ready3;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    wr_valid3 = 1'b0;
    if (!done) check("p3_accept_timeout", 32'd0, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check("p3_pre_oe", {31'd0, dq_oe3}, 32'd1);
      check("p3_pre_dqs", {31'd0, dqs3}, 32'd0);
      check("p3_pre_dq", {16'd0, dq3}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      check("p3_dq", {16'd0, dq3}, 32'h5000 + 32'(k));
      check("p3_dqs", {31'd0, dqs3}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("p3_idx", {29'd0, beat_idx3}, 32'(k));
    end
    @(posedge clk); #2;
    check("p3_post_oe", {31'd0, dq_oe3}, 32'd1);
    check("p3_post_dqs", {31'd0, dqs3}, 32'd0);
    @(posedge clk); #2;
    check("p3_idle_oe", {31'd0, dq_oe3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_mask = '0;
    wr_valid3 = 1'b0; wr_data3 = '0; wr_mask3 = '0;
    #3;
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dqs", {31'd0, dqs}, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #2;
    check("ready_after_rst", {31'd0, wr_ready}, 32'd1);
    check("ready3_after_rst", {31'd0, wr_ready3}, 32'd1);

    // Single burst with timing
    single_burst(16'h1000, 8'h00);

    // Back-to-back: second burst offered mid-burst chains with no preamble
    send_burst(16'h1000, 8'h00, 1'b0);
    wr_valid = 1'b0;
    wait_beat(3'd2);
    send_burst(16'h2000, 8'h00, 1'b1);
    wr_valid = 1'b0;
    wait_drain();

    // Backpressure: valid held high across three bursts
    send_burst(16'h3000, 8'h00, 1'b0);
    send_burst(16'h3100, 8'h0f, 1'b1);
    send_burst(16'h3200, 8'hf0, 1'b1);
    wr_valid = 1'b0;
    wait_drain();

    // Mask pattern
    single_burst(16'h4000, 8'b1010_0101);

    // Reset mid-burst
    send_burst(16'h6000, 8'h00, 1'b0);
    wr_valid = 1'b0;
    wait_beat(3'd4);
    #2 reset = 1'b0;
    #1;
    check("arst_dq", {16'd0, dq}, 32'd0);
    check("arst_dqs", {31'd0, dqs}, 32'd0);
    check("arst_oe", {31'd0, dq_oe}, 32'd0);
    check("arst_dm", {31'd0, dm}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #2;
    check("arst_ready", {31'd0, wr_ready}, 32'd1);
    check("arst_idle_oe", {31'd0, dq_oe}, 32'd0);
    single_burst(16'h7000, 8'h81);

    // PREAMBLE_CYCLES=3 instance
    p3_burst();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_write_serializer.md
Name: ddr_write_serializer

Overview:
- Write-path transmitter inside the DDR controller; the outbound counterpart of the read-capture ring buffer.
- Accepts one full 8-beat write burst (8 x 16 bits plus per-beat mask) over a valid/ready handshake.
- Serializes the burst onto the DRAM-side bus, one beat per clk, with a strobe that toggles on every beat plus preamble and postamble.
- A one-entry holding register allows gapless back-to-back bursts.

Parameters:
- DATA_W, 16, width of one beat on dq.
- BURST_LEN, 8, beats per burst; must be a power of 2.
- PREAMBLE_CYCLES, 1, cycles of dqs=0 with dq_oe=1 before the first beat of a non-chained burst; range 1..3.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  burst offered.
- wr_ready  out  1  holding register free.
- wr_data  in  BURST_LEN*DATA_W  burst data; beat k = wr_data[k*DATA_W +: DATA_W].
- wr_mask  in  BURST_LEN  per-beat mask; bit k=1 masks beat k.
- dq  out  DATA_W  beat data to DRAM.
- dm  out  1  data mask for the current beat.
- dqs  out  1  write strobe; toggles each beat.
- dq_oe  out  1  bus drive enable.
- beat_idx  out  $clog2(BURST_LEN)  index of the beat currently on dq; 0 outside BURST.
- busy  out  1  state != IDLE or holding register valid.

Behaviour:
- All outputs are registered.
- While reset=0: dq=0, dm=0, dqs=0, dq_oe=0, beat_idx=0, busy=0, wr_ready=0. State=IDLE, holding register and shifter cleared.
- One cycle after release, wr_ready=1.
- Handshake:
  - Accept occurs on a posedge with wr_valid && wr_ready; data and mask latch into the holding register (hold_v=1).
  - wr_ready = !hold_v.
  - The holding register transfers to the shifter when the FSM enters BURST beat 0; hold_v clears that same edge.
  - Accept and transfer on the same edge is legal; the new data wins hold_v.
- FSM states: IDLE, PREAMBLE, BURST, POSTAMBLE.
  - IDLE: dq_oe=0, dqs=0, dq=0. If hold_v, go to PREAMBLE and load preamble counter = PREAMBLE_CYCLES-1.
  - PREAMBLE: dq_oe=1, dqs=0, dq=0, dm=0. When counter==0, go to BURST with beat 0 and transfer hold->shifter; otherwise decrement.
  - BURST: dq_oe=1.
    - dq = beat[beat_idx], dm = mask[beat_idx].
    - dqs=1 on even beat_idx, 0 on odd, so every beat boundary is a strobe edge.
    - beat_idx increments per cycle.
    - At beat_idx==BURST_LEN-1: if hold_v, go directly to beat 0 of the next burst with no preamble; dqs continues alternating (odd->even gives 0->1). Otherwise go to POSTAMBLE.
  - POSTAMBLE: exactly one cycle with dq_oe=1, dqs=0, dq=0, dm=0; then IDLE.
    - A burst accepted during POSTAMBLE starts PREAMBLE after IDLE; no shortcut.
- Latency:
  - Accept at edge N in IDLE -> PREAMBLE visible after edge N+1.
  - Beat 0 visible after edge N+1+PREAMBLE_CYCLES.
  - Last beat visible BURST_LEN-1 cycles later.
- Throughput: chained bursts give continuous beats, 100% bus utilization.
- Masked beats still drive dq with the supplied data; dm=1.
- Reset mid-burst: outputs go to 0 immediately (asynchronous); the in-flight and held bursts are discarded, no partial completion.
- wr_valid/wr_data must be held stable while wr_valid && !wr_ready; this is a checker assertion, not enforced by the RTL.

Decomposition:
- definitions.sv gains:
  - enum ddr_wr_state_t {IDLE, PREAMBLE, BURST, POSTAMBLE};
  - constants DDR_BURST_LEN=8 and DDR_DATA_W=16;
  - ulogic128 for the packed burst.
  - Existing ulogic1/ulogic3/ulogic16 typedefs are reused.
- One natural sub-module, ddr_burst_shifter: parallel-load BURST_LEN x DATA_W data + mask register with beat counter, load/advance inputs, and dq/dm/last outputs. The FSM and holding register stay in the top.

Test Plan:
- Single burst, PREAMBLE_CYCLES=1: wr_data beats 16'h1000..16'h1007, mask=0, accepted at cycle 5.
  - Cycle 6: dqs=0, dq_oe=1.
  - Cycles 7-14: dq=1000..1007, dqs=1,0,1,0,1,0,1,0.
  - Cycle 15: postamble.
  - Cycle 16: dq_oe=0.
- Back-to-back: second burst (16'h2000..2007) offered during beat 3 of the first.
  - wr_ready drops after accept.
  - 2000 follows 1007 on the very next cycle with dqs 0->1, no preamble.
  - One postamble after 2007.
- Backpressure: wr_valid held high with three bursts queued.
  - wr_ready=0 whenever hold_v=1.
  - No burst is lost or duplicated; 24 beats appear in order.
- Mask: wr_mask=8'b1010_0101.
  - dm=1 on beats 0,2,5,7 and 0 on the others.
  - dq still carries the supplied data.
- Reset mid-burst: reset=0 at beat 4.
  - dq/dqs/dq_oe/dm go to 0 without waiting for clk.
  - After release: IDLE, wr_ready=1, and the next burst starts with a full preamble.
- PREAMBLE_CYCLES=3: beat 0 appears exactly 4 cycles after accept; dqs=0 throughout the preamble.
